pc_fetch_sequencer: RTL and testbench

- Owns the program counter and the instruction-fetch handshake for the 16-bit RISC core.
- Fetches one instruction at a time from instruction memory and presents it to decode/execute.
- On issue it consumes the decoder's control outputs (pc select, halt, out-register strobe) to choose the next PC, capture OutR data, and stop on HLT.
- Sits between instruction memory and the combinational decoder/datapath.

---
 rtl/pc_fetch_sequencer_if.sv | 34 +++
 rtl/pc_fetch_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer_if
// Instruction-memory fetch bus between the fetch sequencer and the
// instruction memory.
//   imem_req   : fetch request, held high while a fetch is outstanding
//   imem_addr  : word address being fetched
//   imem_ack   : memory presents imem_rdata in this cycle
//   imem_rdata : fetched instruction word
// Modports:
//   master : sequencer side (drives req/addr, receives ack/rdata)
//   slave  : memory side
// -----------------------------------------------------------------------------
interface pc_fetch_sequencer_if #(
  parameter int LENGTH = 16
);
  logic              imem_req;
  logic [LENGTH-1:0] imem_addr;
  logic              imem_ack;
  logic [LENGTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
// Owns the program counter of the 16-bit RISC core and runs the single
// outstanding instruction fetch. A fetched word is held in instr until the
// execute stage accepts it; on that retire cycle the decoder's pc select,
// halt and OutR strobe decide the next PC, the OutR capture and HALT entry.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start               : one-cycle pulse, leaves IDLE or HALT
//   pc_sel, hlt, out_r  : decoder controls, sampled on the retire cycle only
//   branch_off          : signed branch / JAL offset
//   label_addr, rm_val  : absolute jump target, register jump target
//   out_data            : value published on OutR
//   imem                : instruction-memory fetch bus (master side)
//   instr, instr_valid  : instruction presented to decode
//   instr_ready         : execute stage accepts instr this cycle
//   pc, pc_link         : current instruction address and pc+1
//   out_reg, out_valid  : last OutR value and its one-cycle update pulse
//   halted              : high while in HALT
//   retire_cnt          : retired-instruction count (only with RETIRE_CNT_EN)
//
// Build option: define RETIRE_CNT_EN to add the retire_cnt output.
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
  parameter int                LENGTH   = 16,
  parameter logic [LENGTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               pc_sel,
  input  logic                     hlt,
  input  logic                     out_r,
  input  logic signed [LENGTH-1:0] branch_off,
  input  logic [LENGTH-1:0]        label_addr,
  input  logic [LENGTH-1:0]        rm_val,
  input  logic [LENGTH-1:0]        out_data,
  pc_fetch_sequencer_if.master     imem,
  output logic [LENGTH-1:0]        instr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [LENGTH-1:0]        pc,
  output logic [LENGTH-1:0]        pc_link,
  output logic [LENGTH-1:0]        out_reg,
  output logic                     out_valid,
  output logic                     halted
`ifdef RETIRE_CNT_EN
  , output logic [LENGTH-1:0]      retire_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [LENGTH-1:0] pc_nxt;
  logic [LENGTH-1:0] instr_nxt;
  logic              instr_valid_nxt;
  logic [LENGTH-1:0] out_reg_nxt;
  logic              out_valid_nxt;
  logic              retire;
  logic              restart;

  // Next PC for a non-halting retire; all arithmetic wraps modulo 2^LENGTH.
  function automatic logic [LENGTH-1:0] sel_next_pc(
    input logic [1:0]               sel,
    input logic [LENGTH-1:0]        cur,
    input logic signed [LENGTH-1:0] off,
    input logic [LENGTH-1:0]        label,
    input logic [LENGTH-1:0]        rm
  );
    logic [LENGTH-1:0] inc;
    inc = cur + LENGTH'(1);
    case (sel)
      2'd0:    sel_next_pc = inc;
      2'd1:    sel_next_pc = inc + $unsigned(off);
      2'd2:    sel_next_pc = label;
      default: sel_next_pc = rm;
    endcase
  endfunction

  // instr_valid is only ever high in ISSUE, so this is the retire condition.
  assign retire  = instr_valid & instr_ready;
  assign restart = (state == S_HALT) & start;

  assign imem.imem_req  = (state == S_FETCH);
  assign imem.imem_addr = pc;
  assign pc_link        = pc + LENGTH'(1);
  assign halted         = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = instr;
    instr_valid_nxt = instr_valid;
    out_reg_nxt     = out_reg;
    out_valid_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_ack) begin
          instr_nxt       = imem.imem_rdata;
          instr_valid_nxt = 1'b1;
          state_nxt       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (retire) begin
          instr_valid_nxt = 1'b0;
          // hlt wins over pc_sel: the PC stays on the HLT instruction.
          if (hlt) begin
            state_nxt = S_HALT;
          end else begin
            pc_nxt    = sel_next_pc(pc_sel, pc, branch_off, label_addr, rm_val);
            state_nxt = S_FETCH;
          end
          if (out_r) begin
            out_reg_nxt   = out_data;
            out_valid_nxt = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          pc_nxt    = RESET_PC;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      out_reg     <= '0;
      out_valid   <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_valid <= instr_valid_nxt;
      out_reg     <= out_reg_nxt;
      out_valid   <= out_valid_nxt;
    end
  end

`ifdef RETIRE_CNT_EN
  // Counts every retire including HLT; cleared when leaving HALT on start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (restart) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + LENGTH'(1);
    end
  end
`else
  // No retire counter in this build; restart is only used by the counter.
  logic unused_restart;
  assign unused_restart = restart;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Directed bench for pc_fetch_sequencer: sequential fetch, branch/jump/JR/JAL
// targets, ISSUE stall, OutR capture together with HLT, restart, PC wrap and
// reset in the middle of a fetch. Retire counter is checked when
// RETIRE_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  pc_sel;
  logic        hlt;
  logic        out_r;
  logic [15:0] branch_off;
  logic [15:0] label_addr;
  logic [15:0] rm_val;
  logic [15:0] out_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic [15:0] pc_link;
  logic [15:0] out_reg;
  logic        out_valid;
  logic        halted;
`ifdef RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  pc_fetch_sequencer_if #(.LENGTH(16)) imem ();

  pc_fetch_sequencer #(.LENGTH(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pc_sel      (pc_sel),
    .hlt         (hlt),
    .out_r       (out_r),
    .branch_off  (branch_off),
    .label_addr  (label_addr),
    .rm_val      (rm_val),
    .out_data    (out_data),
    .imem        (imem),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .pc_link     (pc_link),
    .out_reg     (out_reg),
    .out_valid   (out_valid),
    .halted      (halted)
`ifdef RETIRE_CNT_EN
    , .retire_cnt (retire_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef RETIRE_CNT_EN
    chk(tag, retire_cnt, exp_cnt);
`endif
  endtask

  // Serve one fetch: wait (bounded) for the request, check the address,
  // hold ack low for lat cycles, then return word.
  task automatic fetch(input logic [15:0] addr, input logic [15:0] word, input int lat);
    int n = 0;
    while (imem.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", imem.imem_req, 1);
    chk("fetch_addr", imem.imem_addr, addr);
    chk("fetch_vld_low", instr_valid, 0);
    repeat (lat) @(negedge clk);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = word;
    @(negedge clk);
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 16'h0000;
    chk("issue_vld", instr_valid, 1);
    chk("issue_instr", instr, word);
    chk("issue_req_low", imem.imem_req, 0);
  endtask

  // Accept the issued instruction with the given decoder controls.
  task automatic retire(input logic [1:0] sel, input logic h, input logic o,
                        input logic [15:0] boff, input logic [15:0] lab,
                        input logic [15:0] rm, input logic [15:0] od);
    pc_sel      = sel;
    hlt         = h;
    out_r       = o;
    branch_off  = boff;
    label_addr  = lab;
    rm_val      = rm;
    out_data    = od;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_sel      = 2'd3;
    hlt         = 1'b0;
    out_r       = 1'b0;
    branch_off  = 16'h5A5A;
    label_addr  = 16'h5A5A;
    rm_val      = 16'h5A5A;
    out_data    = 16'h5A5A;
    exp_cnt++;
    chk("retire_vld_drop", instr_valid, 0);
    chk("retire_out_valid", out_valid, o);
    if (o) chk("retire_out_reg", out_reg, od);
    chk_cnt("retire_cnt");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    pc_sel          = 2'd0;
    hlt             = 1'b0;
    out_r           = 1'b0;
    branch_off      = 16'h0000;
    label_addr      = 16'h0000;
    rm_val          = 16'h0000;
    out_data        = 16'h0000;
    instr_ready     = 1'b0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 16'h0000;

    // Reset state
    @(negedge clk);
    chk("rst_req", imem.imem_req, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_vld", instr_valid, 0);
    chk("rst_out_reg", out_reg, 16'h0000);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk_cnt("rst_cnt");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", imem.imem_req, 0);
    pulse_start();

    // Sequential fetch 0,1,2 with one-cycle memory latency
    fetch(16'h0000, 16'h1000, 1);
    retire(2'd0, 0, 0, 0, 0, 0, 0);
    fetch(16'h0001, 16'h1001, 1);
    retire(2'd0, 0, 0, 0, 0, 0, 0);
    fetch(16'h0002, 16'h1002, 1);
    chk("seq_pc2", pc, 16'h0002);
    retire(2'd0, 0, 0, 0, 0, 0, 0);
    chk("seq_next_addr", imem.imem_addr, 16'h0003);

    // JMP to 5, then backward branch 5+1-4 = 2
    fetch(16'h0003, 16'h2000, 0);
    retire(2'd2, 0, 0, 0, 16'h0005, 0, 0);
    fetch(16'h0005, 16'h2001, 1);
    chk("br_pc", pc, 16'h0005);
    retire(2'd1, 0, 0, 16'hFFFC, 0, 0, 0);
    chk("br_target", imem.imem_addr, 16'h0002);

    // JMP 0x40, JR 0x1234, JMP 0x10
    fetch(16'h0002, 16'h2002, 1);
    retire(2'd2, 0, 0, 0, 16'h0040, 0, 0);
    chk("jmp_target", imem.imem_addr, 16'h0040);
    fetch(16'h0040, 16'h2003, 1);
    retire(2'd3, 0, 0, 0, 0, 16'h1234, 0);
    chk("jr_target", imem.imem_addr, 16'h1234);
    fetch(16'h1234, 16'h2004, 1);
    retire(2'd2, 0, 0, 0, 16'h0010, 0, 0);

    // JAL at 0x10: link value, then jump via Rm to 0xFFFF
    fetch(16'h0010, 16'h2005, 1);
    chk("jal_link", pc_link, 16'h0011);
    retire(2'd3, 0, 0, 0, 0, 16'hFFFF, 0);
    chk("jal_target", imem.imem_addr, 16'hFFFF);

    // Stall in ISSUE for 5 cycles; a start pulse here is ignored
    fetch(16'hFFFF, 16'hA5A5, 1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      @(negedge clk);
      chk("stall_instr", instr, 16'hA5A5);
      chk("stall_pc", pc, 16'hFFFF);
      chk("stall_req", imem.imem_req, 0);
      chk("stall_vld", instr_valid, 1);
      chk("stall_halted", halted, 0);
    end
    start = 1'b0;
    retire(2'd0, 0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem.imem_addr, 16'h0000);

    // Ack in the first FETCH cycle
    fetch(16'h0000, 16'h3000, 0);
    retire(2'd0, 0, 0, 0, 0, 0, 0);

    // OutR plus HLT on the same retire; hlt beats pc_sel
    fetch(16'h0001, 16'h3001, 1);
    retire(2'd2, 1, 1, 0, 16'h0077, 0, 16'hBEEF);
    chk("hlt_halted", halted, 1);
    chk("hlt_pc", pc, 16'h0001);
    chk("hlt_req", imem.imem_req, 0);
    @(negedge clk);
    chk("hlt_out_valid_pulse", out_valid, 0);
    chk("hlt_out_reg_hold", out_reg, 16'hBEEF);
    chk("hlt_still_halted", halted, 1);
    chk("hlt_pc_hold", pc, 16'h0001);
    chk_cnt("hlt_cnt_hold");

    // Restart from HALT goes back to RESET_PC and clears the counter
    pulse_start();
    exp_cnt = 0;
    chk("restart_halted", halted, 0);
    chk("restart_req", imem.imem_req, 1);
    chk("restart_addr", imem.imem_addr, 16'h0000);
    chk_cnt("restart_cnt");

    // Reset in FETCH: request drops at once, a late ack is ignored
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", imem.imem_req, 0);
    chk("midrst_out_reg", out_reg, 16'h0000);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 16'hDEAD;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("late_ack_vld", instr_valid, 0);
    chk("late_ack_instr", instr, 16'h0000);
    chk("late_ack_req", imem.imem_req, 0);
    chk("late_ack_pc", pc, 16'h0000);
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 16'h0000;

    // Normal operation after reset
    pulse_start();
    fetch(16'h0000, 16'h4000, 1);
    retire(2'd0, 0, 1, 0, 0, 0, 16'h0123);
    chk("post_rst_addr", imem.imem_addr, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
